// File: rtl/group_checker.sv
// group_checker: registered validity check for one 4-cell Sudoku group.
// Diagnostic outputs are built only when GROUPCHECK_DIAG_EN is defined.
module group_checker (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] groupDigits,
    output logic        groupCorrect,
    output logic        groupComplete,
    output logic        groupConflict,
    output logic        rangeError,
    output logic [3:0]  presentMask
);

    // Digits 1..4 map to bits 0..3; empty and out-of-range cells vanish.
    function automatic logic [3:0] decodeDigit(input logic [3:0] d);
        logic [3:0] hot;
        case (d)
            4'd1:    hot = 4'b0001;
            4'd2:    hot = 4'b0010;
            4'd3:    hot = 4'b0100;
            4'd4:    hot = 4'b1000;
            default: hot = 4'b0000;
        endcase
        return hot;
    endfunction

    logic [3:0] cellDigit [4];
    logic [3:0] cellHot   [4];
    logic [3:0] maskNext;
    logic       rangeNext;
    logic       correctNext;

    // Split the packed input into cells, decode them and merge the results.
    always_comb begin
        maskNext  = 4'b0000;
        rangeNext = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cellDigit[i] = groupDigits[4*(3-i) +: 4];
            cellHot[i]   = decodeDigit(cellDigit[i]);
            maskNext     = maskNext | cellHot[i];
            rangeNext    = rangeNext | (cellDigit[i] > 4'd4);
        end
        correctNext = (maskNext == 4'b1111) && !rangeNext;
    end

    // Verdict register; reset wins over evaluation.
    always_ff @(posedge CLK) begin
        if (RST) begin
            groupCorrect <= 1'b0;
        end else begin
            groupCorrect <= correctNext;
        end
    end

`ifdef GROUPCHECK_DIAG_EN
    logic completeNext;
    logic conflictNext;

    // Pairwise overlap of one-hot cells flags a repeated digit.
    always_comb begin
        completeNext = (cellDigit[0] != 4'd0) && (cellDigit[1] != 4'd0) &&
                       (cellDigit[2] != 4'd0) && (cellDigit[3] != 4'd0);
        conflictNext = |((cellHot[0] & cellHot[1]) |
                         (cellHot[0] & cellHot[2]) |
                         (cellHot[0] & cellHot[3]) |
                         (cellHot[1] & cellHot[2]) |
                         (cellHot[1] & cellHot[3]) |
                         (cellHot[2] & cellHot[3]));
    end

    // Diagnostic registers, aligned with the verdict.
    always_ff @(posedge CLK) begin
        if (RST) begin
            groupComplete <= 1'b0;
            groupConflict <= 1'b0;
            rangeError    <= 1'b0;
            presentMask   <= 4'b0000;
        end else begin
            groupComplete <= completeNext;
            groupConflict <= conflictNext;
            rangeError    <= rangeNext;
            presentMask   <= maskNext;
        end
    end
`else
    assign groupComplete = 1'b0;
    assign groupConflict = 1'b0;
    assign rangeError    = 1'b0;
    assign presentMask   = 4'b0000;
`endif

endmodule

// File: tb/tb_group_checker.sv
// tb_group_checker: scoreboard bench for group_checker.
// Expected outputs are modelled independently by counting digits.
module tb_group_checker;

`ifdef GROUPCHECK_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] groupDigits = 16'h0000;
    logic        groupCorrect;
    logic        groupComplete;
    logic        groupConflict;
    logic        rangeError;
    logic [3:0]  presentMask;

    int errors = 0;
    int checks = 0;

    logic [7:0] expQ [$];

    group_checker dut (
        .CLK           (CLK),
        .RST           (RST),
        .groupDigits   (groupDigits),
        .groupCorrect  (groupCorrect),
        .groupComplete (groupComplete),
        .groupConflict (groupConflict),
        .rangeError    (rangeError),
        .presentMask   (presentMask)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Packs {correct, complete, conflict, range, mask[3:0]}.
    function automatic logic [7:0] model(input logic [15:0] g,
                                         input logic rst);
        int cnt [5];
        logic complete, conflict, range, correct;
        logic [3:0] mask;
        logic [3:0] d;
        for (int k = 0; k < 5; k++) cnt[k] = 0;
        complete = 1'b1;
        range = 1'b0;
        for (int c = 0; c < 4; c++) begin
            d = g[15-4*c -: 4];
            if (d == 0) complete = 1'b0;
            else if (d > 4) range = 1'b1;
            else cnt[d]++;
        end
        mask = 4'b0000;
        conflict = 1'b0;
        correct = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            if (cnt[k] >= 1) mask[k-1] = 1'b1;
            if (cnt[k] >= 2) conflict = 1'b1;
            if (cnt[k] != 1) correct = 1'b0;
        end
        if (range) correct = 1'b0;
        if (rst) return 8'h00;
        if (!DIAG) return {correct, 7'b0};
        return {correct, complete, conflict, range, mask};
    endfunction

    task automatic step(input string tag, input logic [15:0] g,
                        input logic rst);
        logic [7:0] exp;
        RST = rst;
        groupDigits = g;
        expQ.push_back(model(g, rst));
        @(posedge CLK);
        #1;
        exp = expQ.pop_front();
        check(tag, {groupCorrect, groupComplete, groupConflict,
                    rangeError, presentMask}, exp);
    endtask

    logic [15:0] badVec [6] = '{16'h0000, 16'h1111, 16'h1231,
                                16'h1221, 16'h4411, 16'h1433};
    logic [15:0] diagVec [4] = '{16'h0231, 16'h0024, 16'h1534, 16'hF321};
    logic [15:0] permVec [4] = '{16'h4321, 16'h2143, 16'h3412, 16'h4231};

    initial begin
        @(posedge CLK);
        #1;
        step("rst_hold0", 16'h1324, 1'b1);
        step("rst_hold1", 16'h1324, 1'b1);
        step("rst_release", 16'h1324, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step($sformatf("bad%0d_a", i), badVec[i], 1'b0);
            step($sformatf("bad%0d_b", i), badVec[i], 1'b0);
        end
        step("perm_1324", 16'h1324, 1'b0);
        step("perm_1423", 16'h1423, 1'b0);
        step("perm_again", 16'h1324, 1'b0);
        step("drop_1221", 16'h1221, 1'b0);
        for (int i = 0; i < 4; i++)
            step($sformatf("diag%0d", i), diagVec[i], 1'b0);
        for (int i = 0; i < 4; i++)
            step($sformatf("perm%0d", i), permVec[i], 1'b0);
        step("pre_pulse", 16'h1324, 1'b0);
        step("rst_pulse", 16'h1324, 1'b1);
        step("post_pulse", 16'h1324, 1'b0);
        for (int i = 0; i < 40; i++)
            step($sformatf("rand%0d", i), 16'($urandom_range(0, 16'hFFFF)),
                 1'b0);
        for (int i = 0; i < 20; i++)
            step($sformatf("rsmall%0d", i),
                 {4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                  4'($urandom_range(0, 4)), 4'($urandom_range(0, 4))},
                 1'b0);
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d left, 0 required", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
